io_bus_bridge: RTL and testbench
================================

Name: io_bus_bridge

Overview:
- Parametrised, registered successor to the combinational I/O select logic of the simple-machine CPU.
- Sits between the CPU I/O port and N peripheral devices; one transaction in flight at a time.
- Request/acknowledge handshake on both sides.
- Per-access timeout, and error reporting for unmapped or unresponsive devices.

Parameters:
- N_DEV, 8, number of attached device slots (1..16)
- SEL_W, 3, width of dev_sel; must satisfy 2**SEL_W >= N_DEV
- REG_W, 2, register-select width forwarded to devices
- DATA_W, 16, data width
- TIMEOUT, 15, cycles in ACCESS without ack before abort (>=1)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req  in  1  CPU access request, sampled in IDLE
- dev_sel  in  SEL_W  target device index
- reg_sel  in  REG_W  target register within device
- we  in  1  1 = write, 0 = read
- data_out  in  DATA_W  CPU write data
- data_in  out  DATA_W  read data, valid when done=1
- done  out  1  one-cycle completion pulse
- err  out  1  qualifies done: unmapped index or timeout
- busy  out  1  high from acceptance until done
- dev_cs  out  N_DEV  one-hot chip select, registered
- dev_bus  out  1+REG_W+DATA_W  {we, reg_sel, data_out}, latched at acceptance, broadcast to all devices
- dev_rdata  in  N_DEV*DATA_W  packed device read data; slot k at [k*DATA_W +: DATA_W]
- dev_ack  in  N_DEV  per-device acknowledge

Behaviour:
- Reset (asynchronous, active-high) forces:
  - state = IDLE
  - all outputs 0: data_in, done, err, busy, dev_cs, dev_bus
  - timeout counter = 0
- Reset is honoured mid-transaction; the aborted access is not reported.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - req=1 and dev_sel < N_DEV: latch dev_sel, reg_sel, we, data_out. Next cycle: dev_cs[dev_sel]=1, busy=1, counter=0, go to ACCESS.
  - req=1 and dev_sel >= N_DEV: go to DONE with err=1, data_in=0. No chip select is asserted at any time.
  - req=0: stay in IDLE.
- ACCESS:
  - dev_ack of the selected slot = 1: capture data_in from that slot on reads (data_in unchanged on writes), err=0, drop dev_cs, go to DONE.
  - Otherwise increment the counter. On the cycle the counter reaches TIMEOUT-1 without ack: err=1, data_in=0, drop dev_cs, go to DONE.
  - An ack on the same cycle as the timeout limit wins; no error.
  - Acks from non-selected slots are ignored.
- DONE:
  - done=1 for exactly one cycle; busy drops with it; go to IDLE.
  - err is held until the next acceptance.
- req while busy=1 is ignored; the CPU must hold or re-issue after done.
- Earliest re-acceptance is the cycle after done.
- Latency:
  - ack held from the first cs cycle: req -> done in 3 cycles.
  - unmapped index: req -> done in 2 cycles.
  - timeout: req -> done in TIMEOUT+2 cycles.
- dev_bus stays stable for the whole ACCESS phase, even if the CPU inputs change.
- dev_cs is never more than one-hot, and is all-zero outside ACCESS.
- Counter width is $clog2(TIMEOUT+1). It never wraps, because it is cleared on acceptance.

Decomposition:
- Shared package io_pkg holds:
  - FSM state encoding: IDLE=2'd0, ACCESS=2'd1, DONE=2'd2
  - default widths: DATA_W, REG_W
  - bus-field offset constants for {we, reg_sel, data}, so device-side decoders slice dev_bus consistently
- One natural sub-module: io_timeout_ctr, a loadable saturating counter with clear, enable and terminal-count output; instantiated once.
- The read mux over dev_rdata and the one-hot cs decode stay inline.

Test Plan:
- Read hit: reset, then req with dev_sel=2, reg_sel=1, we=0; device 2 acks on the first cs cycle with 16'hBEEF -> dev_cs=8'b0000_0100 for 1 cycle, done at cycle 3, data_in=16'hBEEF, err=0.
- Write broadcast: dev_sel=5, reg_sel=3, we=1, data_out=16'h1234; ack after 4 cycles -> dev_bus=19'h7_1234 stable throughout ACCESS, done with err=0, data_in unchanged.
- Unmapped index: N_DEV=6, dev_sel=7 -> dev_cs stays 0, done+err at cycle 2, data_in=0.
- Timeout: TIMEOUT=15, device 0 never acks -> cs high exactly 15 cycles, then done+err, data_in=0. Variant with ack on the 15th cycle -> err=0.
- Busy/ignored request and stray ack: toggle req and dev_sel during ACCESS, and pulse dev_ack[3] while dev_sel=1 -> no new cs, no early completion, latched fields unchanged.
- Reset mid-ACCESS: assert reset two cycles into an access -> all outputs 0 immediately (asynchronously), no done pulse; a fresh req afterwards completes normally.

Source files
------------

// File: rtl/io_bus_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : io_pkg
// Description : Shared FSM encoding, default widths and dev_bus field layout.
// Revision    : 1.0 - initial release
// ============================================================================
package io_pkg;

    localparam int c_DEF_DATA_W = 16;
    localparam int c_DEF_REG_W  = 2;

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_ACCESS = 2'd1;
    localparam logic [1:0] c_DONE   = 2'd2;

    // dev_bus layout is {we, reg_sel, data}, data in the low bits
    localparam int c_BUS_DATA_LSB = 0;
    localparam int c_BUS_REG_LSB  = c_DEF_DATA_W;
    localparam int c_BUS_WE_BIT   = c_DEF_DATA_W + c_DEF_REG_W;
    localparam int c_BUS_W        = c_BUS_WE_BIT + 1;

    function automatic int bus_we_bit(input int data_w, input int reg_w);
        return data_w + reg_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/io_bus_bridge_if.sv
`default_nettype none
// ============================================================================
// Module      : io_bus_bridge_if
// Description : CPU-side and device-side signals of the I/O bus bridge.
// Revision    : 1.0 - initial release
// ============================================================================
interface io_bus_bridge_if
    import io_pkg::*;
#(
    parameter int N_DEV  = 8,
    parameter int SEL_W  = 3,
    parameter int REG_W  = c_DEF_REG_W,
    parameter int DATA_W = c_DEF_DATA_W
);
    logic                      req;
    logic [SEL_W-1:0]          dev_sel;
    logic [REG_W-1:0]          reg_sel;
    logic                      we;
    logic [DATA_W-1:0]         data_out;
    logic [DATA_W-1:0]         data_in;
    logic                      done;
    logic                      err;
    logic                      busy;
    logic [N_DEV-1:0]          dev_cs;
    logic [REG_W+DATA_W:0]     dev_bus;
    logic [N_DEV*DATA_W-1:0]   dev_rdata;
    logic [N_DEV-1:0]          dev_ack;

    modport slave (
        input  req, dev_sel, reg_sel, we, data_out, dev_rdata, dev_ack,
        output data_in, done, err, busy, dev_cs, dev_bus
    );

    modport master (
        output req, dev_sel, reg_sel, we, data_out, dev_rdata, dev_ack,
        input  data_in, done, err, busy, dev_cs, dev_bus
    );

endinterface
`default_nettype wire

// File: rtl/io_bus_bridge_timeout_ctr.sv
`default_nettype none
// ============================================================================
// Module      : io_timeout_ctr
// Description : Loadable saturating up-counter with clear, enable and
//               terminal-count flag.
// Revision    : 1.0 - initial release
// ============================================================================
module io_timeout_ctr #(
    parameter int WIDTH = 4,
    parameter int MAX   = 14
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_clr,
    input  wire logic             i_en,
    input  wire logic             i_load,
    input  wire logic [WIDTH-1:0] i_load_val,
    output logic                  o_tc
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && !o_tc) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_tc = (r_count == WIDTH'(MAX));

endmodule
`default_nettype wire

// File: rtl/io_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module      : io_bus_bridge
// Description : Registered CPU-to-device I/O bridge, one access in flight,
//               with per-access timeout and unmapped-index error reporting.
// Revision    : 1.0 - initial release
// ============================================================================
module io_bus_bridge
    import io_pkg::*;
#(
    parameter int N_DEV   = 8,
    parameter int SEL_W   = 3,
    parameter int REG_W   = c_DEF_REG_W,
    parameter int DATA_W  = c_DEF_DATA_W,
    parameter int TIMEOUT = 15
) (
    input  wire logic       clk,
    input  wire logic       reset,
    io_bus_bridge_if.slave  bus
);

    localparam int c_BUS_BITS = REG_W + DATA_W + 1;
    localparam int c_WE_BIT   = bus_we_bit(DATA_W, REG_W);
    localparam int c_CNT_W    = $clog2(TIMEOUT + 1);

    logic [1:0]            r_state;
    logic [N_DEV-1:0]      r_cs;
    logic [c_BUS_BITS-1:0] r_bus;
    logic [DATA_W-1:0]     r_data_in;
    logic                  r_done;
    logic                  r_err;
    logic                  r_busy;

    logic                  w_mapped;
    logic [N_DEV-1:0]      w_cs_dec;
    logic                  w_ack;
    logic [DATA_W-1:0]     w_rdata;
    logic                  w_accept;
    logic                  w_tc;

    assign w_mapped = (32'(bus.dev_sel) < N_DEV);
    assign w_accept = (r_state == c_IDLE) && bus.req;
    // Only the latched chip select qualifies acks, so strays are ignored
    assign w_ack    = |(bus.dev_ack & r_cs);

    always_comb begin
        w_cs_dec = '0;
        w_rdata  = '0;
        for (int k = 0; k < N_DEV; k++) begin
            if (bus.dev_sel == SEL_W'(k)) w_cs_dec[k] = 1'b1;
            if (r_cs[k]) w_rdata = bus.dev_rdata[k*DATA_W +: DATA_W];
        end
    end

    io_timeout_ctr #(
        .WIDTH (c_CNT_W),
        .MAX   (TIMEOUT - 1)
    ) u_timeout_ctr (
        .clk        (clk),
        .rst        (reset),
        .i_clr      (w_accept),
        .i_en       ((r_state == c_ACCESS) && !w_ack),
        .i_load     (1'b0),
        .i_load_val ({c_CNT_W{1'b0}}),
        .o_tc       (w_tc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= c_IDLE;
            r_cs      <= '0;
            r_bus     <= '0;
            r_data_in <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (bus.req) begin
                        r_busy <= 1'b1;
                        if (w_mapped) begin
                            r_cs    <= w_cs_dec;
                            r_bus   <= {bus.we, bus.reg_sel, bus.data_out};
                            r_err   <= 1'b0;
                            r_state <= c_ACCESS;
                        end else begin
                            r_err     <= 1'b1;
                            r_data_in <= '0;
                            r_state   <= c_DONE;
                        end
                    end
                end
                c_ACCESS: begin
                    // Ack is checked first so it wins over a same-cycle timeout
                    if (w_ack) begin
                        if (!r_bus[c_WE_BIT]) r_data_in <= w_rdata;
                        r_err   <= 1'b0;
                        r_cs    <= '0;
                        r_state <= c_DONE;
                    end else if (w_tc) begin
                        r_err     <= 1'b1;
                        r_data_in <= '0;
                        r_cs      <= '0;
                        r_state   <= c_DONE;
                    end
                end
                c_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= c_IDLE;
                end
                default: begin
                    r_cs    <= '0;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign bus.data_in = r_data_in;
    assign bus.done    = r_done;
    assign bus.err     = r_err;
    assign bus.busy    = r_busy;
    assign bus.dev_cs  = r_cs;
    assign bus.dev_bus = r_bus;

endmodule
`default_nettype wire

// File: tb/tb_io_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_io_bus_bridge
// Description : Directed self-checking bench for io_bus_bridge (8 and 6 slots).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_io_bus_bridge;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    io_bus_bridge_if #(.N_DEV(8), .SEL_W(3), .REG_W(2), .DATA_W(16)) b8 ();
    io_bus_bridge_if #(.N_DEV(6), .SEL_W(3), .REG_W(2), .DATA_W(16)) b6 ();

    io_bus_bridge #(.N_DEV(8), .SEL_W(3), .REG_W(2), .DATA_W(16), .TIMEOUT(15)) dut8 (
        .clk(clk), .reset(reset), .bus(b8.slave));
    io_bus_bridge #(.N_DEV(6), .SEL_W(3), .REG_W(2), .DATA_W(16), .TIMEOUT(15)) dut6 (
        .clk(clk), .reset(reset), .bus(b6.slave));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        b8.req = 0; b8.dev_sel = 0; b8.reg_sel = 0; b8.we = 0; b8.data_out = 0;
        b8.dev_rdata = '0; b8.dev_ack = '0;
        b6.req = 0; b6.dev_sel = 0; b6.reg_sel = 0; b6.we = 0; b6.data_out = 0;
        b6.dev_rdata = '0; b6.dev_ack = '0;
        step(); step();
        checks++; if ({b8.data_in, b8.done, b8.err, b8.busy, b8.dev_cs, b8.dev_bus} !== '0) begin failures++; $display("FAIL reset_outputs8 got=%h exp=0", {b8.data_in, b8.done, b8.err, b8.busy, b8.dev_cs, b8.dev_bus}); end
        checks++; if ({b6.data_in, b6.done, b6.err, b6.busy, b6.dev_cs, b6.dev_bus} !== '0) begin failures++; $display("FAIL reset_outputs6 got=%h exp=0", {b6.data_in, b6.done, b6.err, b6.busy, b6.dev_cs, b6.dev_bus}); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_read_hit();
        b8.dev_rdata[2*16 +: 16] = 16'hBEEF;
        b8.dev_ack = 8'b0000_0100;
        b8.req = 1; b8.dev_sel = 3'd2; b8.reg_sel = 2'd1; b8.we = 0; b8.data_out = 16'h0000;
        step();
        b8.req = 0;
        checks++; if (b8.dev_cs !== 8'b0000_0100) begin failures++; $display("FAIL read_cs got=%b exp=00000100", b8.dev_cs); end
        checks++; if (b8.busy !== 1'b1) begin failures++; $display("FAIL read_busy got=%b exp=1", b8.busy); end
        step();
        b8.dev_ack = '0;
        checks++; if ({b8.dev_cs, b8.done} !== 9'd0) begin failures++; $display("FAIL read_cs_drop got=%h exp=0", {b8.dev_cs, b8.done}); end
        step();
        checks++; if ({b8.done, b8.err, b8.busy} !== 3'b100) begin failures++; $display("FAIL read_done got=%b exp=100", {b8.done, b8.err, b8.busy}); end
        checks++; if (b8.data_in !== 16'hBEEF) begin failures++; $display("FAIL read_data got=%h exp=beef", b8.data_in); end
        step();
        checks++; if (b8.done !== 1'b0) begin failures++; $display("FAIL read_done_pulse got=%b exp=0", b8.done); end
    endtask

    task automatic test_write_broadcast();
        b8.req = 1; b8.dev_sel = 3'd5; b8.reg_sel = 2'd3; b8.we = 1; b8.data_out = 16'h1234;
        step();
        b8.req = 0; b8.we = 0; b8.data_out = 16'hFFFF; b8.reg_sel = 2'd0;
        for (int i = 0; i < 4; i++) begin
            checks++; if ({b8.dev_bus, b8.dev_cs, b8.done} !== {19'h7_1234, 8'b0010_0000, 1'b0}) begin failures++; $display("FAIL write_access[%0d] bus=%h cs=%b done=%b exp bus=71234 cs=00100000 done=0", i, b8.dev_bus, b8.dev_cs, b8.done); end
            if (i < 3) step();
        end
        b8.dev_ack = 8'b0010_0000;
        step();
        b8.dev_ack = '0;
        step();
        checks++; if ({b8.done, b8.err} !== 2'b10) begin failures++; $display("FAIL write_done got=%b exp=10", {b8.done, b8.err}); end
        checks++; if (b8.data_in !== 16'hBEEF) begin failures++; $display("FAIL write_data_in_kept got=%h exp=beef", b8.data_in); end
        step();
    endtask

    task automatic test_unmapped();
        b6.dev_rdata[4*16 +: 16] = 16'h5A5A;
        b6.dev_ack = 6'b01_0000;
        b6.req = 1; b6.dev_sel = 3'd4; b6.we = 0;
        step(); b6.req = 0; step(); b6.dev_ack = '0; step();
        checks++; if ({b6.done, b6.data_in} !== {1'b1, 16'h5A5A}) begin failures++; $display("FAIL unmap_pre_read got=%h exp=15a5a", {b6.done, b6.data_in}); end
        b6.req = 1; b6.dev_sel = 3'd7;
        step();
        b6.req = 0;
        checks++; if ({b6.dev_cs, b6.done} !== 7'd0) begin failures++; $display("FAIL unmap_cs1 got=%h exp=0", {b6.dev_cs, b6.done}); end
        step();
        checks++; if ({b6.done, b6.err, b6.dev_cs} !== {2'b11, 6'd0}) begin failures++; $display("FAIL unmap_done got=%b exp=11000000", {b6.done, b6.err, b6.dev_cs}); end
        checks++; if (b6.data_in !== 16'h0000) begin failures++; $display("FAIL unmap_data got=%h exp=0", b6.data_in); end
        step();
        checks++; if ({b6.done, b6.err} !== 2'b01) begin failures++; $display("FAIL unmap_err_held got=%b exp=01", {b6.done, b6.err}); end
    endtask

    task automatic test_timeout();
        int  cs_cycles = 0;
        int  lat = 1;
        bit  seen = 0;
        b8.dev_ack = '0;
        b8.req = 1; b8.dev_sel = 3'd0; b8.we = 0;
        step();
        b8.req = 0;
        if (b8.dev_cs !== '0) cs_cycles++;
        for (int i = 0; i < 40 && !seen; i++) begin
            step();
            lat++;
            if (b8.dev_cs !== '0) cs_cycles++;
            if (b8.done === 1'b1) seen = 1;
        end
        checks++; if (seen !== 1'b1) begin failures++; $display("FAIL timeout_no_done got=%b exp=1", seen); end
        checks++; if (lat !== 17) begin failures++; $display("FAIL timeout_latency got=%0d exp=17", lat); end
        checks++; if (cs_cycles !== 15) begin failures++; $display("FAIL timeout_cs_cycles got=%0d exp=15", cs_cycles); end
        checks++; if ({b8.err, b8.data_in} !== {1'b1, 16'h0000}) begin failures++; $display("FAIL timeout_err got=%h exp=10000", {b8.err, b8.data_in}); end
        step();
    endtask

    task automatic test_timeout_ack_wins();
        b8.dev_rdata[0 +: 16] = 16'h0F0F;
        b8.req = 1; b8.dev_sel = 3'd0; b8.we = 0;
        step();
        b8.req = 0;
        for (int i = 0; i < 14; i++) step();
        checks++; if ({b8.dev_cs, b8.done} !== {8'b0000_0001, 1'b0}) begin failures++; $display("FAIL ackwin_cs15 got=%h exp=2", {b8.dev_cs, b8.done}); end
        b8.dev_ack = 8'b0000_0001;
        step();
        b8.dev_ack = '0;
        step();
        checks++; if ({b8.done, b8.err, b8.data_in} !== {2'b10, 16'h0F0F}) begin failures++; $display("FAIL ackwin_done got=%h exp=20f0f", {b8.done, b8.err, b8.data_in}); end
        step();
    endtask

    task automatic test_back_to_back_busy();
        b8.req = 1; b8.dev_sel = 3'd1; b8.reg_sel = 2'd2; b8.we = 1; b8.data_out = 16'hA5A5;
        step();
        for (int i = 0; i < 4; i++) begin
            b8.req = i[0]; b8.dev_sel = (i[0]) ? 3'd3 : 3'd6; b8.data_out = 16'h1111;
            b8.we = 0; b8.dev_ack = 8'b0000_1000;
            checks++; if ({b8.dev_cs, b8.done, b8.busy, b8.dev_bus} !== {8'b0000_0010, 2'b01, 19'h6_A5A5}) begin failures++; $display("FAIL busy_ignore[%0d] cs=%b done=%b busy=%b bus=%h exp cs=00000010 done=0 busy=1 bus=6a5a5", i, b8.dev_cs, b8.done, b8.busy, b8.dev_bus); end
            step();
        end
        b8.req = 0; b8.dev_ack = 8'b0000_0010;
        step();
        b8.dev_ack = '0;
        step();
        checks++; if ({b8.done, b8.err} !== 2'b10) begin failures++; $display("FAIL busy_done got=%b exp=10", {b8.done, b8.err}); end
        step();
    endtask

    task automatic test_reset_mid_access();
        b8.req = 1; b8.dev_sel = 3'd4; b8.we = 0;
        step();
        b8.req = 0;
        step();
        #2 reset = 1'b1;
        #1;
        checks++; if ({b8.data_in, b8.done, b8.err, b8.busy, b8.dev_cs, b8.dev_bus} !== '0) begin failures++; $display("FAIL midreset_async got=%h exp=0", {b8.data_in, b8.done, b8.err, b8.busy, b8.dev_cs, b8.dev_bus}); end
        step();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if ({b8.done, b8.busy, b8.dev_cs} !== 10'd0) begin failures++; $display("FAIL midreset_quiet[%0d] got=%h exp=0", i, {b8.done, b8.busy, b8.dev_cs}); end
        end
        b8.dev_rdata[6*16 +: 16] = 16'h1357;
        b8.dev_ack = 8'b0100_0000;
        b8.req = 1; b8.dev_sel = 3'd6;
        step();
        b8.req = 0;
        checks++; if (b8.dev_cs !== 8'b0100_0000) begin failures++; $display("FAIL midreset_fresh_cs got=%b exp=01000000", b8.dev_cs); end
        step();
        b8.dev_ack = '0;
        step();
        checks++; if ({b8.done, b8.err, b8.data_in} !== {2'b10, 16'h1357}) begin failures++; $display("FAIL midreset_fresh_done got=%h exp=21357", {b8.done, b8.err, b8.data_in}); end
    endtask

    initial begin
        test_reset();
        test_read_hit();
        test_write_broadcast();
        test_unmapped();
        test_timeout();
        test_timeout_ack_wins();
        test_back_to_back_busy();
        test_reset_mid_access();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
